ram_responder: RTL

Synthesizable RAM-side responder for the cache-to-RAM line-transfer interface. It is the target end of the cache's ram_addr/ram_avalid/ram_rnw/ram_wdata/ram_rdata/ram_ack port.
- Accepts line writes as 4 x 16-bit beats into a line-organized memory.
- Returns line reads as 4 beats after a fixed latency.
- Exposes the last committed line on a backdoor port for bench checking.
It replaces the behavioural RAM stub in cache system benches and serves as the RAM model in the full system.

---
 rtl/ram_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram_responder.sv
// RAM-side target for the cache line-transfer port: 4-beat line writes into a
// line-organized memory, 4-beat line reads after a fixed latency.
module ram_responder #(
    parameter int ADDR_SIZE = 13,
    parameter int WORD_SIZE = 16,
    parameter int LINE_SIZE = 64,
    parameter int LATENCY   = 4
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 ram_busy,
    output logic                 ram_err,
    output logic [LINE_SIZE-1:0] data_backdoor
);
    localparam int BEATS = LINE_SIZE / WORD_SIZE;
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int CW    = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_ACK, RD_WAIT, RD_BURST} state_t;

    state_t                            r_state, w_next;
    logic [ADDR_SIZE-1:0]              r_addr;
    logic [BEATS-1:0][WORD_SIZE-1:0]   r_line;
    logic [BEATS-1:0][WORD_SIZE-1:0]   w_gen_line, w_rd_line, w_wr_line;
    logic [LINE_SIZE-1:0]              r_mem [DEPTH];
    logic [DEPTH-1:0]                  r_valid;
    logic [CW-1:0]                     r_cnt;
    logic [3:0]                        r_wait;
    logic                              w_wr_last;

    // Unwritten lines read back as {beat index, 0, line address}
    for (genvar g = 0; g < BEATS; g++) begin : g_gen
        assign w_gen_line[g] = {2'(g), (WORD_SIZE-2)'(ram_addr)};
    end

    assign w_rd_line = r_valid[ram_addr] ? r_mem[ram_addr] : w_gen_line;
    assign w_wr_last = (r_state == WR_COLLECT) && (r_cnt == CW'(BEATS-1));
    assign ram_busy  = (r_state != IDLE);

    always_comb begin
        w_wr_line            = r_line;
        w_wr_line[BEATS-1]   = ram_wdata;
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (ram_avalid)
                            w_next = !ram_rnw ? WR_COLLECT :
                                     (LATENCY == 1) ? RD_BURST : RD_WAIT;
            WR_COLLECT: if (r_cnt == CW'(BEATS-1)) w_next = WR_ACK;
            WR_ACK:     w_next = IDLE;
            RD_WAIT:    if (r_wait == '0) w_next = RD_BURST;
            RD_BURST:   if (r_cnt == CW'(BEATS)) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Ack/rdata are registered so both drop cleanly in the reset cycle
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            r_addr        <= '0;
            r_line        <= '0;
            r_cnt         <= '0;
            r_wait        <= '0;
            r_valid       <= '0;
            ram_rdata     <= '0;
            ram_ack       <= 1'b0;
            ram_err       <= 1'b0;
            data_backdoor <= '0;
        end else begin
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
            if (ram_avalid && r_state != IDLE) ram_err <= 1'b1;
            case (r_state)
                IDLE: if (ram_avalid) begin
                    r_addr <= ram_addr;
                    if (!ram_rnw) begin
                        r_line[0] <= ram_wdata;
                        r_cnt     <= CW'(1);
                    end else begin
                        r_line <= w_rd_line;
                        if (LATENCY == 1) begin
                            ram_ack   <= 1'b1;
                            ram_rdata <= w_rd_line[0];
                            r_cnt     <= CW'(1);
                        end else begin
                            r_wait <= 4'(LATENCY - 2);
                        end
                    end
                end
                WR_COLLECT: begin
                    r_line[r_cnt[CW-2:0]] <= ram_wdata;
                    r_cnt                 <= r_cnt + CW'(1);
                    if (w_wr_last) begin
                        r_valid[r_addr] <= 1'b1;
                        data_backdoor   <= w_wr_line;
                        ram_ack         <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (r_wait == '0) begin
                        ram_ack   <= 1'b1;
                        ram_rdata <= r_line[0];
                        r_cnt     <= CW'(1);
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                RD_BURST: if (r_cnt != CW'(BEATS)) begin
                    ram_ack   <= 1'b1;
                    ram_rdata <= r_line[r_cnt[CW-2:0]];
                    r_cnt     <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Array contents survive reset; the valid vector hides stale lines
    always_ff @(posedge ram_clk) begin
        if (!ram_rst && w_wr_last) r_mem[r_addr] <= w_wr_line;
    end
endmodule
